// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and
// default bit timing. The transmitter uses the same package.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 1 MHz system clock, 9600 baud
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // ones_odd is the XOR over data bits and the received parity bit.
    // Returns 1 when that total disagrees with the selected mode.
    function automatic logic parity_bad(input int mode, input logic ones_odd);
        logic bad;
        bad = 1'b0;
        if (mode == PAR_ODD)  bad = ~ones_odd;
        if (mode == PAR_EVEN) bad = ones_odd;
        return bad;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, per-bit cycle counter and a
// 3-sample majority vote around the bit centre. bit_strobe_o pulses for
// one cycle at cyc = M+1 with the voted value on bit_val_o.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    input  logic restart_i,     // hold cyc at 0 while high
    output logic rxs_o,         // synchronised line
    output logic rxs_ok_o,      // synchroniser holds a real line sample
    output logic bit_strobe_o,
    output logic bit_val_o,
    output logic bit_end_o      // last cycle of the current bit
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int M  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] C_PRE = CW'(M - 1);
    localparam logic [CW-1:0] C_MID = CW'(M);
    localparam logic [CW-1:0] C_DEC = CW'(M + 1);
    localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          samp_pre_q, samp_mid_q;
    logic          rxs;

    assign rxs      = sync_q[1];
    assign rxs_o    = rxs;
    assign rxs_ok_o = fill_q[1];

    // Counter next value: restart wins, otherwise wrap at the end of a bit
    always_comb begin
        cyc_d = cyc_q + CW'(1);
        if (restart_i || (cyc_q == C_END)) cyc_d = '0;
    end

    // Synchroniser (preset high = idle line), fill tracker, counter, samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            fill_q     <= 2'b00;
            cyc_q      <= '0;
            samp_pre_q <= 1'b1;
            samp_mid_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            fill_q <= {fill_q[0], 1'b1};
            cyc_q  <= cyc_d;
            if (cyc_q == C_PRE) samp_pre_q <= rxs;
            if (cyc_q == C_MID) samp_mid_q <= rxs;
        end
    end

    // Majority of the samples at M-1, M and the live sample at M+1
    always_comb begin
        bit_val_o    = (samp_pre_q & samp_mid_q) | (samp_pre_q & rxs) | (samp_mid_q & rxs);
        bit_strobe_o = !restart_i && (cyc_q == C_DEC);
        bit_end_o    = !restart_i && (cyc_q == C_END);
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote sampling, optional parity,
// one or two stop bits and a valid/ready output.
//
// Handshake: a word is transferred at a clk edge where data_valid and
// data_ready are both high; data_valid drops the next cycle. data_out and
// its flags stay stable while data_valid is high. A frame completing while
// a word is held and not being accepted is dropped and sets overrun, which
// clears on the next transfer.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 perr_frm_q, perr_frm_d;
    logic                 ferr_frm_q, ferr_frm_d;
    logic                 prev_q;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic rxs, rxs_ok, bit_strobe, bit_val, bit_end, restart;
    logic decide, new_ferr, accept;

    // Counter is parked while waiting for a start edge or for the line to recover
    assign restart = (state_q == ST_IDLE) || (state_q == ST_BREAK);

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx),
        .restart_i   (restart),
        .rxs_o       (rxs),
        .rxs_ok_o    (rxs_ok),
        .bit_strobe_o(bit_strobe),
        .bit_val_o   (bit_val),
        .bit_end_o   (bit_end)
    );

    // Frame FSM: next state and per-frame accumulators
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        perr_frm_d = perr_frm_q;
        ferr_frm_d = ferr_frm_q;
        decide     = 1'b0;
        new_ferr   = ferr_frm_q | ~bit_val;
        case (state_q)
            ST_IDLE: begin
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                perr_frm_d = 1'b0;
                ferr_frm_d = 1'b0;
                if (prev_q && !rxs) state_d = ST_START;
            end
            ST_START: begin
                if (bit_strobe && bit_val) state_d = ST_IDLE;
                else if (bit_end)          state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_strobe) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_strobe) perr_frm_d = parity_bad(PARITY, (^shift_q) ^ bit_val);
                if (bit_end)    state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_strobe) begin
                    ferr_frm_d = new_ferr;
                    // Final stop bit decides at its centre so the next start
                    // edge can be caught without waiting for the bit end
                    if (stop_idx_q == LAST_STOP) begin
                        decide  = 1'b1;
                        state_d = new_ferr ? ST_BREAK : ST_IDLE;
                    end
                end
                if (bit_end) stop_idx_d = 1'b1;
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output word register and handshake
    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        accept       = data_valid_q & data_ready;
        if (accept) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end
        if (decide) begin
            if (!data_valid_q || accept) begin
                data_out_d   = shift_q;
                parity_err_d = perr_frm_q;
                frame_err_d  = new_ferr;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers; prev_q stays low until the synchroniser
    // carries a real sample so a line held low through reset is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            perr_frm_q   <= 1'b0;
            ferr_frm_q   <= 1'b0;
            prev_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            perr_frm_q   <= perr_frm_d;
            ferr_frm_q   <= ferr_frm_d;
            prev_q       <= rxs_ok ? rxs : 1'b0;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB = 104;
  localparam int W   = 12;  // {dut_id, frame_err, parity_err, data[8:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;

  // DUT A: 8N1
  logic       rx_a = 1'b1;
  logic       ready_a = 1'b0;
  logic [7:0] dout_a;
  logic       dv_a, pe_a, fe_a, ov_a, busy_a;

  // DUT B: 7 data bits, even parity, 1 stop
  logic       rx_b = 1'b1;
  logic       ready_b = 1'b0;
  logic [6:0] dout_b;
  logic       dv_b, pe_b, fe_b, ov_b, busy_b;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  // ---------------- clock / reset ----------------
  always #500 clk = ~clk;  // 1 MHz

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a),
    .data_out(dout_a), .data_valid(dv_a), .data_ready(ready_a),
    .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .busy(busy_a)
  );

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b),
    .data_out(dout_b), .data_valid(dv_b), .data_ready(ready_b),
    .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .busy(busy_b)
  );

  // Record every transfer, sampled mid-cycle (inputs change 2 ns after posedge)
  always @(negedge clk) begin
    if (dv_a && ready_a) got_q.push_back({1'b0, fe_a, pe_a, 1'b0, dout_a});
    if (dv_b && ready_b) got_q.push_back({1'b1, fe_b, pe_b, 2'b00, dout_b});
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit, input logic stop_val);
    drive_rx(which, 1'b0);
    tick(CPB);
    for (int i = 0; i < nbits; i++) begin
      drive_rx(which, data[i]);
      tick(CPB);
    end
    if (has_par) begin
      drive_rx(which, par_bit);
      tick(CPB);
    end
    drive_rx(which, stop_val);
    tick(CPB);
    if (stop_val) drive_rx(which, 1'b1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front();
      else                  g = 'x;
      check(tag, g, e);
    end
    check({tag, "_extra_words"}, W'(got_q.size()), W'(0));
    got_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick(3);
    // reset values while rst is asserted
    check("rst_data_out", W'(dout_a), W'(0));
    check("rst_valid",    W'(dv_a),   W'(0));
    check("rst_perr",     W'(pe_a),   W'(0));
    check("rst_ferr",     W'(fe_a),   W'(0));
    check("rst_overrun",  W'(ov_a),   W'(0));
    check("rst_busy",     W'(busy_a), W'(0));
    rst = 1'b0;
    tick(20);

    // 8N1 back-to-back frames, consumer always ready
    ready_a = 1'b1;
    send_frame(0, 9'h014, 8, 1'b0, 1'b0, 1'b1);
    send_frame(0, 9'h02C, 8, 1'b0, 1'b0, 1'b1);
    send_frame(0, 9'h042, 8, 1'b0, 1'b0, 1'b1);
    tick(20);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 9'h014});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 9'h02C});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 9'h042});
    check_sb("8n1_words");

    // 7E1: 0x2C has three ones, so the even parity bit is 1
    ready_b = 1'b1;
    send_frame(1, 9'h02C, 7, 1'b1, 1'b1, 1'b1);
    tick(50);
    send_frame(1, 9'h02C, 7, 1'b1, 1'b0, 1'b1);
    tick(20);
    exp_q.push_back({1'b1, 1'b0, 1'b0, 9'h02C});
    exp_q.push_back({1'b1, 1'b0, 1'b1, 9'h02C});
    check_sb("7e1_words");

    // 1-cycle glitch: START entered 3 edges later, voted out at cyc=M+1=53
    rx_a = 1'b0;
    tick(1);
    rx_a = 1'b1;
    tick(55);
    check("glitch1_busy_in_start", W'(busy_a), W'(1));
    tick(1);
    check("glitch1_busy_cleared",  W'(busy_a), W'(0));
    tick(100);

    // 40-cycle low pulse: still high across the M-1..M+1 samples
    rx_a = 1'b0;
    tick(40);
    rx_a = 1'b1;
    tick(16);
    check("glitch40_busy_in_start", W'(busy_a), W'(1));
    tick(1);
    check("glitch40_busy_cleared",  W'(busy_a), W'(0));
    tick(100);
    check_sb("glitch_no_words");

    // Stop bit low, line held low 300 cycles: word delivered with frame_err
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0);
    tick(196);
    check("break_busy_held", W'(busy_a), W'(1));
    rx_a = 1'b1;
    tick(2);
    check("break_busy_until_rxs", W'(busy_a), W'(1));
    tick(1);
    check("break_busy_released",  W'(busy_a), W'(0));
    tick(20);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 9'h0A5});
    check_sb("ferr_word");

    // Overrun: consumer stalled across two frames
    ready_a = 1'b0;
    send_frame(0, 9'h014, 8, 1'b0, 1'b0, 1'b1);
    check("ovr_first_valid",   W'(dv_a),   W'(1));
    check("ovr_first_data",    W'(dout_a), W'(8'h14));
    check("ovr_first_overrun", W'(ov_a),   W'(0));
    send_frame(0, 9'h042, 8, 1'b0, 1'b0, 1'b1);
    tick(5);
    check("ovr_held_data",  W'(dout_a), W'(8'h14));
    check("ovr_held_valid", W'(dv_a),   W'(1));
    check("ovr_flag_set",   W'(ov_a),   W'(1));
    ready_a = 1'b1;
    tick(1);
    ready_a = 1'b0;
    check("ovr_valid_after_hs",   W'(dv_a), W'(0));
    check("ovr_overrun_after_hs", W'(ov_a), W'(0));
    tick(10);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 9'h014});
    check_sb("ovr_words");

    // Reset in the middle of DATA, released while the line is still low
    ready_a = 1'b1;
    tick(50);
    rx_a = 1'b0;
    tick(CPB);        // start bit
    tick(CPB);        // bit0 of 0x42 = 0
    rx_a = 1'b1;
    tick(50);         // partway into bit1
    rst = 1'b1;
    tick(3);
    rx_a = 1'b0;
    check("midrst_data_out", W'(dout_a), W'(0));
    check("midrst_busy",     W'(busy_a), W'(0));
    rst = 1'b0;
    tick(200);
    check("midrst_low_busy",  W'(busy_a), W'(0));
    check("midrst_low_valid", W'(dv_a),   W'(0));
    rx_a = 1'b1;
    tick(200);
    send_frame(0, 9'h042, 8, 1'b0, 1'b0, 1'b1);
    tick(20);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 9'h042});
    check_sb("midrst_words");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
